// File: rtl/dma_byte_gearbox_if.sv
// Byte-lane write/read handshake bundle for dma_byte_gearbox.
// slave is the gearbox side, master is the producer/consumer side.
interface dma_byte_gearbox_if #(
  parameter int BYTES = 8
);
  localparam int CW = $clog2(BYTES) + 1;

  logic [8*BYTES-1:0] w_data;
  logic [CW-1:0]      w_bytes;
  logic               w_valid;
  logic               w_ready;

  logic [8*BYTES-1:0] r_data;
  logic [CW-1:0]      r_bytes;
  logic               r_ready;
  logic               r_valid;

  modport master (
    output w_data, w_bytes, w_valid, r_bytes, r_ready,
    input  w_ready, r_data, r_valid
  );

  modport slave (
    input  w_data, w_bytes, w_valid, r_bytes, r_ready,
    output w_ready, r_data, r_valid
  );
endinterface

// File: rtl/dma_byte_gearbox.sv
// Byte-granular circular buffer: writes and reads move 1..BYTES bytes per cycle,
// byte 0 of each lane is the oldest byte, with zero-latency read data.
module dma_byte_gearbox #(
  parameter int BYTES  = 8,
  parameter int DEPTH  = 32,
  parameter int AF_LVL = DEPTH - BYTES,
  parameter int AE_LVL = BYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    err_clr,
  dma_byte_gearbox_if.slave       bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    err_width
);

  localparam int CW = $clog2(BYTES) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [CW-1:0] BYTES_C = CW'(BYTES);
  localparam logic [LW:0]   DEPTH_C = (LW+1)'(DEPTH);
  localparam logic [LW-1:0] AF_C    = LW'(AF_LVL);
  localparam logic [LW-1:0] AE_C    = LW'(AE_LVL);

  typedef logic [PW-1:0] ptr_t;

  // NOTE: the storage array carries no reset; pointers and level alone define
  // which bytes are meaningful, so clearing the array would only cost logic.
  logic [7:0] mem [DEPTH];

  ptr_t             rp;
  ptr_t             wp;
  logic             w_ok;
  logic             r_ok;
  logic             wr_fire;
  logic             rd_fire;
  logic             err_set;
  logic [LW:0]      w_sum;
  logic [LW-1:0]    wr_cnt;
  logic [LW-1:0]    rd_cnt;
  logic [8*BYTES-1:0] r_data_c;

  // Handshake qualifiers use the registered level only; no same-cycle credit.
  assign w_ok  = (bus.w_bytes != '0) && (bus.w_bytes <= BYTES_C);
  assign r_ok  = (bus.r_bytes != '0) && (bus.r_bytes <= BYTES_C);
  assign w_sum = {1'b0, level} + (LW+1)'(bus.w_bytes);

  assign bus.w_ready = w_ok && (w_sum <= DEPTH_C);
  assign bus.r_valid = r_ok && (level >= LW'(bus.r_bytes));

  assign wr_fire = bus.w_valid && bus.w_ready;
  assign rd_fire = bus.r_ready && bus.r_valid;
  assign err_set = (bus.w_valid && !w_ok) || (bus.r_ready && !r_ok);

  assign wr_cnt = wr_fire ? LW'(bus.w_bytes) : '0;
  assign rd_cnt = rd_fire ? LW'(bus.r_bytes) : '0;

  assign almost_full  = (level >= AF_C);
  assign almost_empty = (level <= AE_C);

  // Bytes past the requested count, or past what is actually stored, read as
  // zero so unwritten (unreset) storage never leaks onto r_data.
  always_comb begin
    // NOTE: default assignment first keeps this always_comb free of latches.
    r_data_c = '0;
    for (int i = 0; i < BYTES; i++) begin
      if ((i < int'(bus.r_bytes)) && (i < int'(level))) begin
        r_data_c[8*i +: 8] = mem[rp + PW'(i)];
      end
    end
  end

  assign bus.r_data = r_data_c;

  // Pointer arithmetic is modulo DEPTH by width, which makes wrap seamless.
  always_ff @(posedge clk) begin
    if (rst && !flush && wr_fire) begin
      for (int i = 0; i < BYTES; i++) begin
        if (i < int'(bus.w_bytes)) begin
          mem[wp + PW'(i)] <= bus.w_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of statement order.
      rp    <= '0;
      wp    <= '0;
      level <= '0;
    end else if (flush) begin
      rp    <= '0;
      wp    <= '0;
      level <= '0;
    end else begin
      if (wr_fire) wp <= wp + PW'(bus.w_bytes);
      if (rd_fire) rp <= rp + PW'(bus.r_bytes);
      // Realign to the start of storage whenever the buffer sits idle and empty.
      if (!wr_fire && !rd_fire && (level == '0)) begin
        rp <= '0;
        wp <= '0;
      end
      level <= level - rd_cnt + wr_cnt;
    end
  end

  // A bad count in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_width <= 1'b0;
    end else if (err_set) begin
      err_width <= 1'b1;
    end else if (err_clr) begin
      err_width <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_byte_gearbox.sv
// Scoreboard bench for dma_byte_gearbox (BYTES=8, DEPTH=32): a byte queue
// models storage; bytes are queued on accepted writes and popped on reads.
module tb_dma_byte_gearbox;

  localparam int BYTES = 8;
  localparam int DEPTH = 32;
  localparam int CW    = 4;
  localparam int LW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          err_clr;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          almost_empty;
  logic          err_width;

  dma_byte_gearbox_if #(.BYTES(BYTES)) bus ();

  dma_byte_gearbox #(.BYTES(BYTES), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .err_clr      (err_clr),
    .bus          (bus),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .err_width    (err_width)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb [$];
  logic       m_err    = 1'b0;
  logic [7:0] next_byte = 8'h01;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check combinational outputs, clock, update
  // the model, then check registered outputs.
  task automatic cycle(input logic wv, input int wn, input logic rr, input int rn,
                       input logic fl = 1'b0, input logic ec = 1'b0, input logic rs = 1'b1);
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_wr;
    logic        exp_rv;
    logic        w_legal;
    logic        r_legal;
    int          lvl;
    lvl = sb.size();
    wd  = '0;
    for (int i = 0; i < BYTES; i++) wd[8*i +: 8] = next_byte + 8'(i);

    bus.w_valid = wv;
    bus.w_bytes = CW'(wn);
    bus.w_data  = wd;
    bus.r_ready = rr;
    bus.r_bytes = CW'(rn);
    flush       = fl;
    err_clr     = ec;
    rst         = rs;
    #1;

    w_legal = (wn >= 1) && (wn <= BYTES);
    r_legal = (rn >= 1) && (rn <= BYTES);
    exp_wr  = w_legal && (lvl + wn <= DEPTH);
    exp_rv  = r_legal && (lvl >= rn);
    exp_rd  = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (i < rn && i < lvl) exp_rd[8*i +: 8] = sb[i];
    end
    check("w_ready", 64'(bus.w_ready), 64'(exp_wr));
    check("r_valid", 64'(bus.r_valid), 64'(exp_rv));
    if (exp_rv || lvl == 0) check("r_data", bus.r_data, exp_rd);

    @(posedge clk);
    #1;
    if (!rs) begin
      sb.delete();
      m_err = 1'b0;
    end else begin
      if (fl) begin
        sb.delete();
      end else begin
        if (rr && exp_rv) repeat (rn) void'(sb.pop_front());
        if (wv && exp_wr) begin
          for (int i = 0; i < wn; i++) sb.push_back(wd[8*i +: 8]);
          next_byte = next_byte + 8'(wn);
        end
      end
      if ((wv && !w_legal) || (rr && !r_legal)) m_err = 1'b1;
      else if (ec) m_err = 1'b0;
    end
    check("level", 64'(level), 64'(sb.size()));
    check("err_width", 64'(err_width), 64'(m_err));
    check("almost_full", 64'(almost_full), 64'(sb.size() >= DEPTH - BYTES));
    check("almost_empty", 64'(almost_empty), 64'(sb.size() <= BYTES));
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && sb.size() > 0; k++) begin
      cycle(1'b0, 8, 1'b1, (sb.size() < BYTES) ? sb.size() : BYTES);
    end
    check("drained", 64'(level), 64'd0);
  endtask

  initial begin
    rst         = 1'b0;
    flush       = 1'b0;
    err_clr     = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_bytes = CW'(8);
    bus.w_data  = '0;
    bus.r_ready = 1'b0;
    bus.r_bytes = CW'(8);
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b0, 8, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8, 1'b0, 8);

    // Single 8-byte write, 3-byte read.
    next_byte = 8'h01;
    cycle(1'b1, 8, 1'b0, 3);
    cycle(1'b0, 8, 1'b1, 3);
    drain();

    // Fill to full, blocked fifth write, read frees space.
    repeat (4) cycle(1'b1, 8, 1'b0, 8);
    cycle(1'b1, 8, 1'b0, 8);
    cycle(1'b1, 8, 1'b1, 8);
    cycle(1'b1, 8, 1'b0, 8);
    drain();

    // Simultaneous read and write at level 8.
    cycle(1'b1, 8, 1'b0, 8);
    cycle(1'b1, 8, 1'b1, 8);
    cycle(1'b0, 8, 1'b1, 8);
    drain();

    // 5-byte bursts against 3-byte reads, wrapping many times.
    for (int k = 0; k < 40; k++) cycle(1'b1, 5, 1'b1, 3);
    drain();

    // Bad counts, err_clr, error winning over clear, flush.
    cycle(1'b1, 9, 1'b0, 8);
    cycle(1'b0, 8, 1'b0, 8, 1'b0, 1'b1);
    cycle(1'b0, 8, 1'b1, 0);
    cycle(1'b1, 0, 1'b0, 8, 1'b0, 1'b1);
    cycle(1'b0, 8, 1'b0, 8, 1'b0, 1'b1);
    cycle(1'b1, 8, 1'b0, 8);
    cycle(1'b1, 8, 1'b0, 8);
    cycle(1'b1, 4, 1'b0, 8);
    cycle(1'b0, 8, 1'b0, 8, 1'b1);
    cycle(1'b0, 8, 1'b1, 1);
    cycle(1'b1, 8, 1'b0, 8);
    cycle(1'b1, 8, 1'b1, 8, 1'b1);
    cycle(1'b0, 8, 1'b1, 8);

    // Reset at level 12 with a write pending and the error flag set.
    cycle(1'b1, 8, 1'b0, 8);
    cycle(1'b1, 4, 1'b0, 8);
    cycle(1'b1, 9, 1'b0, 8);
    cycle(1'b1, 8, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8, 1'b0, 8);
    cycle(1'b1, 6, 1'b0, 8);
    cycle(1'b0, 8, 1'b1, 6);

    // Random mix of legal counts.
    for (int k = 0; k < 150; k++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)),
            1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_byte_gearbox.md
DMA_BYTE_GEARBOX -- requirements
Module: dma_byte_gearbox

Interface
REQ-001 SHALL have parameter BYTES, default 8: lane width in bytes; power of 2, range 2..16.
REQ-002 SHALL have parameter DEPTH, default 32: storage in bytes; power of 2, at least 2*BYTES.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-BYTES: almost-full threshold in bytes.
REQ-004 SHALL have parameter AE_LVL, default BYTES: almost-empty threshold in bytes.
REQ-005 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port flush  in  1  synchronous clear of contents.
REQ-008 SHALL have port w_data  in  8*BYTES  write bytes; byte 0 (bits 7:0) is the oldest.
REQ-009 SHALL have port w_bytes  in  clog2(BYTES)+1  write byte count.
REQ-010 SHALL have port w_valid  in  1  write request.
REQ-011 SHALL have port w_ready  out  1  space for w_bytes available.
REQ-012 SHALL have port r_data  out  8*BYTES  read bytes; byte 0 is the oldest stored byte.
REQ-013 SHALL have port r_bytes  in  clog2(BYTES)+1  read byte count.
REQ-014 SHALL have port r_ready  in  1  read request.
REQ-015 SHALL have port r_valid  out  1  at least r_bytes stored.
REQ-016 SHALL have port level  out  clog2(DEPTH)+1  stored byte count.
REQ-017 SHALL have ports almost_full and almost_empty  out  1  asserted when level>=AF_LVL and level<=AE_LVL respectively.
REQ-018 SHALL have ports err_width  out  1  (sticky bad-count flag) and err_clr  in  1  (clears it).

Function
REQ-019 w_ready SHALL be combinational: (level + w_bytes <= DEPTH) and 1<=w_bytes<=BYTES, with level being the registered value; a same-cycle read SHALL NOT be credited.
REQ-020 r_valid SHALL be combinational: (level >= r_bytes) and 1<=r_bytes<=BYTES; a same-cycle write SHALL NOT be credited.
REQ-021 A write SHALL fire when w_valid&&w_ready: byte i, for i<w_bytes, stored at mem[(wp+i) mod DEPTH]; wp += w_bytes, wrapping.
REQ-022 A read SHALL fire when r_ready&&r_valid: rp += r_bytes, wrapping.
REQ-023 r_data byte i SHALL equal mem[(rp+i) mod DEPTH] for i<r_bytes and zero for i>=r_bytes, with zero read latency; written bytes SHALL first be visible the cycle after the write.
REQ-024 Simultaneous read and write SHALL both fire; level_next = level - rd_count + wr_count.
REQ-025 Wrap-around SHALL be seamless: a transfer straddling mem[DEPTH-1] and mem[0] SHALL preserve byte order.
REQ-026 When level==0 and neither transfer fires, rp and wp SHALL return to 0 (realign idle).
REQ-027 flush SHALL take priority over both transfers: next cycle rp=wp=level=0; memory contents are don't-care.
REQ-028 A request (w_valid or r_ready) with count 0 or count>BYTES SHALL set err_width on the next cycle and SHALL NOT transfer.
REQ-029 err_clr SHALL clear err_width on the next cycle; a same-cycle error SHALL win over err_clr.
REQ-030 Mem SHALL be a plain register array with no reset; only pointers, level and err_width are reset.

Reset
REQ-031 When rst==0 at a clock edge: rp=wp=level=0 and err_width=0; rst SHALL override flush and all transfers.
REQ-032 Values during and after reset: w_ready=1 for legal w_bytes, r_valid=0, almost_empty=1, almost_full=0, r_data=0.
REQ-033 A reset asserted mid-transfer SHALL discard all stored bytes; no partial write commits.

Verification (BYTES=8, DEPTH=32)
REQ-034 Write 8 bytes 0x0807060504030201, then read r_bytes=3 -> r_data=0x030201, upper bytes 0, level 8->5.
REQ-035 Write four 8-byte words, then a fifth write -> w_ready=0 at level 32, almost_full=1; read 8 -> w_ready=1 next cycle.
REQ-036 Write 5-byte bursts while reading 3 per cycle for 40 cycles -> output stream equals input byte sequence across wrap, no loss.
REQ-037 At level 8: read 8 and write 8 in the same cycle -> level stays 8, r_data = old bytes, new bytes appear next cycle.
REQ-038 w_valid with w_bytes=9 -> no write, err_width=1; err_clr -> err_width=0; flush at level 20 -> level=0, r_valid=0.
REQ-039 Drive rst=0 at level 12 with w_valid=1 -> level=0, pointers 0, err_width=0 next cycle.
